// File: rtl/am_attenuator.sv
// am_attenuator: three-stage operator attenuation pipeline.
//   p1: env + (tl << 2)
//   p2: + ksl_att + tremolo depth (only when the slot's AM bit is set)
//   p3: clamp to 511, flag the clamp
// Idle stages keep their data registers so the outputs stay put between slots.
// Optional saturation counter: define AM_ATTENUATOR_SAT_COUNT_EN to add the
// sat_cnt_clr input and the 16-bit sat_cnt output.
module am_attenuator #(
  parameter int BANK_NUM_WIDTH = 1,
  parameter int OP_NUM_WIDTH   = 5,
  parameter int AM_VAL_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_p0,
  input  logic [BANK_NUM_WIDTH-1:0] bank_num_p0,
  input  logic [OP_NUM_WIDTH-1:0]   op_num_p0,
  input  logic [8:0]                env_p0,
  input  logic [5:0]                tl_p0,
  input  logic [7:0]                ksl_att_p0,
  input  logic                      am_p0,
  input  logic [AM_VAL_WIDTH-1:0]   am_val_p2,
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
  input  logic                      sat_cnt_clr,
  output logic [15:0]               sat_cnt,
`endif
  output logic [8:0]                att_p3,
  output logic                      valid_p3,
  output logic [BANK_NUM_WIDTH-1:0] bank_num_p3,
  output logic [OP_NUM_WIDTH-1:0]   op_num_p3,
  output logic                      sat_p3
);

  localparam int STAGES = 3;

  // vld_pipe[k] is the valid bit of the slot sitting in stage k
  logic [STAGES:1] vld_pipe;

  logic [9:0]                s1;
  logic [7:0]                ksl1;
  logic                      am1;
  logic [BANK_NUM_WIDTH-1:0] bank1, bank2;
  logic [OP_NUM_WIDTH-1:0]   op1, op2;
  logic [10:0]               s2;
  logic [10:0]               s2_nxt;

  // tremolo depth joins here; it belongs to the slot currently in stage 1
  always_comb begin
    s2_nxt = {1'b0, s1} + 11'(ksl1) + (am1 ? 11'(am_val_p2) : 11'd0);
  end

  // valid shift register; never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], valid_p0};
  end

  // stage 1: base attenuation, capture AM bit, ksl and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      ksl1  <= '0;
      am1   <= 1'b0;
      bank1 <= '0;
      op1   <= '0;
    end else if (valid_p0) begin
      s1    <= {1'b0, env_p0} + {2'b00, tl_p0, 2'b00};
      ksl1  <= ksl_att_p0;
      am1   <= am_p0;
      bank1 <= bank_num_p0;
      op1   <= op_num_p0;
    end
  end

  // stage 2: add key scaling and tremolo
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2    <= '0;
      bank2 <= '0;
      op2   <= '0;
    end else if (vld_pipe[1]) begin
      s2    <= s2_nxt;
      bank2 <= bank1;
      op2   <= op1;
    end
  end

  // stage 3: clamp to the 9-bit range; exactly 511 is not a clamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      att_p3      <= '0;
      sat_p3      <= 1'b0;
      bank_num_p3 <= '0;
      op_num_p3   <= '0;
    end else if (vld_pipe[2]) begin
      sat_p3      <= |s2[10:9];
      att_p3      <= (|s2[10:9]) ? 9'h1FF : s2[8:0];
      bank_num_p3 <= bank2;
      op_num_p3   <= op2;
    end
  end

  assign valid_p3 = vld_pipe[3];

`ifdef AM_ATTENUATOR_SAT_COUNT_EN
  // count clamped results; clear beats a simultaneous event, count sticks at max
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      sat_cnt <= '0;
    else if (sat_cnt_clr)                            sat_cnt <= '0;
    else if (valid_p3 && sat_p3 && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_am_attenuator.sv
// Bench for am_attenuator: a cycle-history model predicts every output at each
// negedge; directed slots additionally pin literal results.
// Define AM_ATTENUATOR_SAT_COUNT_EN to also exercise the saturation counter.
module tb_am_attenuator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_p0 = 1'b0;
  logic [0:0] bank_num_p0 = '0;
  logic [4:0] op_num_p0 = '0;
  logic [8:0] env_p0 = '0;
  logic [5:0] tl_p0 = '0;
  logic [7:0] ksl_att_p0 = '0;
  logic       am_p0 = 1'b0;
  logic [4:0] am_val_p2 = '0;
  logic [8:0] att_p3;
  logic       valid_p3;
  logic [0:0] bank_num_p3;
  logic [4:0] op_num_p3;
  logic       sat_p3;
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
  logic        sat_cnt_clr = 1'b0;
  logic [15:0] sat_cnt;
`endif

  am_attenuator dut (
    .clk(clk), .rst_n(rst_n), .valid_p0(valid_p0), .bank_num_p0(bank_num_p0),
    .op_num_p0(op_num_p0), .env_p0(env_p0), .tl_p0(tl_p0), .ksl_att_p0(ksl_att_p0),
    .am_p0(am_p0), .am_val_p2(am_val_p2),
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt),
`endif
    .att_p3(att_p3), .valid_p3(valid_p3), .bank_num_p3(bank_num_p3),
    .op_num_p3(op_num_p3), .sat_p3(sat_p3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // history of what was presented at each rising edge (ring of 4)
  int   e = 0;
  logic h_v[4], h_rst[4], h_am[4], h_bank[4];
  int   h_env[4], h_tl[4], h_ksl[4], h_op[4], h_amv[4];

  // model outputs after the latest edge
  int m_valid = 0, m_att = 0, m_sat = 0, m_bank = 0, m_op = 0;
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
  int m_cnt = 0;
`endif

  // model: a slot seen at edge n-2 with rst high through edge n is emitted after
  // edge n using the tremolo depth seen at edge n-1; otherwise the outputs hold.
  always @(posedge clk) begin
    int i1, i2, idx, sum;
    idx = e & 3; i1 = (e - 1) & 3; i2 = (e - 2) & 3;
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    if (!rst_n)                                m_cnt = 0;
    else if (sat_cnt_clr)                      m_cnt = 0;
    else if (m_valid == 1 && m_sat == 1 && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
    if (!rst_n) begin
      m_valid = 0; m_att = 0; m_sat = 0; m_bank = 0; m_op = 0;
    end else if (e >= 2 && h_rst[i2] && h_rst[i1] && h_v[i2]) begin
      sum = h_env[i2] + 4 * h_tl[i2] + h_ksl[i2] + (h_am[i2] ? h_amv[i1] : 0);
      m_valid = 1;
      m_sat   = (sum > 511) ? 1 : 0;
      m_att   = (sum > 511) ? 511 : sum;
      m_bank  = int'(h_bank[i2]);
      m_op    = h_op[i2];
    end else begin
      m_valid = 0;
    end
    h_v[idx] = valid_p0; h_rst[idx] = rst_n; h_am[idx] = am_p0; h_bank[idx] = bank_num_p0[0];
    h_env[idx] = int'(env_p0); h_tl[idx] = int'(tl_p0); h_ksl[idx] = int'(ksl_att_p0);
    h_op[idx] = int'(op_num_p0); h_amv[idx] = int'(am_val_p2);
    e++;
  end

  // compare every output against the model each cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", int'(valid_p3), 0);
      check("rst_att",   int'(att_p3),   0);
      check("rst_sat",   int'(sat_p3),   0);
      check("rst_tag",   int'({bank_num_p3, op_num_p3}), 0);
    end else begin
      check("valid_p3", int'(valid_p3), m_valid);
      check("att_p3",   int'(att_p3),   m_att);
      check("sat_p3",   int'(sat_p3),   m_sat);
      check("bank_p3",  int'(bank_num_p3), m_bank);
      check("op_p3",    int'(op_num_p3),   m_op);
    end
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    check("sat_cnt", int'(sat_cnt), rst_n ? m_cnt : 0);
`endif
  end

  // present one cycle of inputs, then move to just after the next rising edge
  task automatic cyc(input logic v, input int bank, input int op, input int env,
                     input int tl, input int ksl, input logic am, input int amv);
    valid_p0 = v; bank_num_p0 = 1'(bank); op_num_p0 = 5'(op); env_p0 = 9'(env);
    tl_p0 = 6'(tl); ksl_att_p0 = 8'(ksl); am_p0 = am; am_val_p2 = 5'(amv);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int amv);
    cyc(1'b0, 0, 0, 0, 0, 0, 1'b0, amv);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("lit_reset_valid", int'(valid_p3), 0);
    check("lit_reset_att", int'(att_p3), 0);
    rst_n = 1'b1;
    idle(0);

    // 100 + 40 + 8 + 26
    cyc(1'b1, 1, 3, 100, 10, 8, 1'b1, 0);
    idle(26); idle(0);
    check("lit_am_valid", int'(valid_p3), 1);
    check("lit_am_att", int'(att_p3), 174);
    check("lit_am_sat", int'(sat_p3), 0);
    check("lit_am_op", int'(op_num_p3), 3);

    // AM disabled ignores the depth
    cyc(1'b1, 0, 4, 100, 10, 8, 1'b0, 0);
    idle(26); idle(0);
    check("lit_noam_att", int'(att_p3), 148);

    // full saturation
    cyc(1'b1, 1, 7, 511, 63, 255, 1'b1, 0);
    idle(26); idle(0);
    check("lit_sat_att", int'(att_p3), 511);
    check("lit_sat_flag", int'(sat_p3), 1);
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    check("lit_cnt_before", int'(sat_cnt), 0);
`endif
    idle(0);
`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    check("lit_cnt_after", int'(sat_cnt), 1);
`endif
    check("lit_hold_att", int'(att_p3), 511);
    check("lit_hold_valid", int'(valid_p3), 0);

    // back-to-back slots with changing depth
    cyc(1'b1, 0, 10, 0, 0, 0, 1'b1, 0);
    cyc(1'b1, 1, 11, 500, 3, 0, 1'b1, 5);
    idle(20);
    check("lit_a_att", int'(att_p3), 5);
    check("lit_a_op", int'(op_num_p3), 10);
    check("lit_a_sat", int'(sat_p3), 0);
    idle(0);
    check("lit_b_valid", int'(valid_p3), 1);
    check("lit_b_att", int'(att_p3), 511);
    check("lit_b_sat", int'(sat_p3), 1);
    check("lit_b_tag", int'({bank_num_p3, op_num_p3}), 32 + 11);

    // exactly 511 is not a clamp
    cyc(1'b1, 0, 12, 500, 2, 3, 1'b0, 0);
    idle(31); idle(0);
    check("lit_511_att", int'(att_p3), 511);
    check("lit_511_sat", int'(sat_p3), 0);

    // reset with slots in flight
    cyc(1'b1, 0, 20, 1, 0, 0, 1'b0, 0);
    cyc(1'b1, 0, 21, 2, 0, 0, 1'b0, 0);
    rst_n = 1'b0;
    cyc(1'b1, 0, 22, 3, 0, 0, 1'b0, 0);
    idle(0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(0);
      check("lit_flush_valid", int'(valid_p3), 0);
    end
    cyc(1'b1, 1, 23, 50, 1, 1, 1'b1, 0);
    idle(9);
    check("lit_lat2_valid", int'(valid_p3), 0);
    idle(0);
    check("lit_lat3_valid", int'(valid_p3), 1);
    check("lit_lat3_att", int'(att_p3), 64);

    // mixed stream with idle gaps, checked by the model
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 511)), int'($urandom_range(0, 63)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 26)));
    idle(0); idle(0); idle(0);

`ifdef AM_ATTENUATOR_SAT_COUNT_EN
    // drive the counter to its ceiling
    for (int i = 0; i < 65535; i++) cyc(1'b1, 0, 1, 511, 63, 255, 1'b0, 0);
    idle(0); idle(0); idle(0);
    check("lit_cnt_max", int'(sat_cnt), 65535);
    cyc(1'b1, 0, 1, 511, 63, 255, 1'b0, 0);
    idle(0); idle(0); idle(0);
    check("lit_cnt_stick", int'(sat_cnt), 65535);
    // clear coincident with a saturation event
    cyc(1'b1, 0, 1, 511, 63, 255, 1'b0, 0);
    idle(0); idle(0);
    check("lit_clr_event", int'(valid_p3 & sat_p3), 1);
    sat_cnt_clr = 1'b1;
    idle(0);
    sat_cnt_clr = 1'b0;
    check("lit_clr_cnt", int'(sat_cnt), 0);
    idle(0);
    check("lit_clr_stay", int'(sat_cnt), 0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/am_attenuator.md
AM_ATTENUATOR -- requirements
Module: am_attenuator

Interface
REQ-001 clk  input  1  system clock; every register updates on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 valid_p0  input  1  operator slot data valid this cycle.
REQ-004 bank_num_p0  input  BANK_NUM_WIDTH (1)  operator bank of the slot.
REQ-005 op_num_p0  input  OP_NUM_WIDTH (5)  operator number of the slot.
REQ-006 env_p0  input  9  envelope attenuation; 0 is loudest, 511 is silent.
REQ-007 tl_p0  input  6  total level; weight is tl<<2.
REQ-008 ksl_att_p0  input  8  key-scale attenuation, already shifted.
REQ-009 am_p0  input  1  AM enable bit of the operator.
REQ-010 am_val_p2  input  AM_VAL_WIDTH (5)  tremolo depth, 0..26; sampled in the cycle the slot is at stage 2.
REQ-011 att_p3  output  9  final operator attenuation.
REQ-012 valid_p3  output  1  att_p3, bank_num_p3 and op_num_p3 are valid.
REQ-013 bank_num_p3, op_num_p3  output  1/5  slot tag delayed with the data.
REQ-014 sat_p3  output  1  att_p3 was clamped to 511.

Function
REQ-015 The block SHALL be a 3-stage pipeline with latency exactly 3 cycles from valid_p0 to valid_p3, with no stalls and one slot accepted per cycle.
REQ-016 Stage 1 SHALL register s1 = env_p0 + (tl_p0<<2) at 10-bit width (maximum 763), together with am_p0, the tag and valid.
REQ-017 Stage 2 SHALL register s2 = s1 + ksl_att + (am ? am_val_p2 : 0) at 11-bit width, using the stage-1 delayed am bit and ksl_att.
REQ-018 Stage 3 SHALL register att_p3 = min(s2, 511), and SHALL set sat_p3 = 1 only when s2 > 511.
REQ-019 am_val_p2 SHALL be used only in stage 2 of the slot it belongs to; a slot with am = 0 SHALL ignore it fully.
REQ-020 When valid is 0 at a stage, that stage SHALL propagate valid = 0 and hold its data registers, so outputs do not toggle on idle slots.
REQ-021 Back-to-back valid slots SHALL each produce an independent result; no state is shared between slots.
REQ-022 A result of exactly 511 SHALL give att_p3 = 511 with sat_p3 = 0.

Reset
REQ-023 While rst_n = 0, all valid bits, att_p3, sat_p3, the tags and all pipeline data SHALL be 0.
REQ-024 Asserting reset mid-stream SHALL drop every in-flight slot; after release, valid_p3 SHALL stay 0 until 3 cycles after the first new valid_p0.

Configuration
REQ-025 Macro AM_ATTENUATOR_SAT_COUNT_EN, when defined, SHALL add input sat_cnt_clr (1 bit) and output sat_cnt (16 bits).
REQ-026 With the macro, sat_cnt SHALL increment once per cycle in which valid_p3 && sat_p3, SHALL saturate at 16'hFFFF, and SHALL reset to 0.
REQ-027 With the macro, sat_cnt_clr = 1 SHALL clear sat_cnt to 0 on the next clock; a clear coincident with a saturation event SHALL win, and that event is not counted.
REQ-028 Without the macro, neither port SHALL exist and no counter logic SHALL be generated; all other behaviour SHALL be identical.

Verification
REQ-029 env=100, tl=10, ksl=8, am=1, am_val_p2=26 -> 3 cycles later valid_p3=1, att_p3=174, sat_p3=0.
REQ-030 Same slot with am=0 and am_val_p2=26 -> att_p3=148.
REQ-031 env=511, tl=63, ksl=255, am=1, am_val=26 -> att_p3=511, sat_p3=1; with the macro, sat_cnt goes 0 -> 1.
REQ-032 Slots A(env=0) and B(env=500, tl=3) on consecutive cycles, with am_val_p2 changing 5 -> 20 and am=1 -> outputs 5 then 511 (sat) on consecutive cycles, each tagged correctly.
REQ-033 Reset pulsed while 3 slots are in flight -> no valid_p3 for those slots; the first slot after release appears exactly 3 cycles after its valid_p0.
REQ-034 Macro: sat_cnt at 16'hFFFF plus another saturation -> stays 16'hFFFF; sat_cnt_clr coincident with a saturation -> next value 0.
